// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Bytes written by the memory block are queued. They are then sent as 8N1
// frames, LSB first, with the line idling high.
// Back-to-back frames are sent with no idle gap whenever the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wen,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full_q, full_d;

  // Serialiser state
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  // Handshake between FIFO and serialiser
  logic              baud_tc_s;
  logic              nonempty_s;
  logic              pop_s;
  logic              push_s;

  // Decode the terminal baud count and the FIFO push/pop decisions for this cycle
  always_comb begin
    baud_tc_s  = (baud_q == BAUD_LAST);
    nonempty_s = (count_q != CNT_ZERO);
    // The serialiser takes a byte only when it is idle, or when a stop bit ends.
    pop_s      = nonempty_s &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_tc_s));
    // A full FIFO still accepts a byte if the head leaves in the same cycle.
    push_s     = tx_wen && ((count_q != CNT_FULL) || pop_s);
  end

  // Next-state logic for FIFO pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (tx_wen && !push_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Frame sequencing: start bit, eight data bits LSB first, stop bit, with a direct reload from STOP
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = BAUD_ZERO;
        tx_d   = 1'b1;
        if (pop_s) begin
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_tc_s) begin
          baud_d    = BAUD_ZERO;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
          tx_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (baud_tc_s) begin
          baud_d = BAUD_ZERO;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            // shift_q[1] becomes the new LSB, so it is the next bit on the line.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_tc_s) begin
          baud_d = BAUD_ZERO;
          if (pop_s) begin
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
          tx_d   = 1'b1;
        end
      end
      default: begin
        baud_d  = BAUD_ZERO;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    // Status flags are computed from next state so that they come out of flops.
    busy_d = (state_d != ST_IDLE) || (count_d != CNT_ZERO);
    full_d = (count_d == CNT_FULL);
  end

  // FIFO byte storage; the data is captured only on an accepted push
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // Register all control state; reset aborts any frame and discards buffered bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= BAUD_ZERO;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_full = full_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmit end of the memory-mapped UART TX register. The memory block issues one-cycle `uart_tx_wen` with `uart_tx_data` valid in the same cycle. This block accepts each write, buffers it, and serialises it on the board TX pin.
- Buffering lets the CPU issue stores back-to-back without polling.
- Frame format is fixed 8N1, LSB first, line idle high.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16, byte entries in the TX FIFO; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_wen  input  1  write strobe from memory block; one byte is pushed per cycle high.
- tx_data  input  8  byte to transmit; sampled only when tx_wen=1.
- tx  output  1  serial line; registered; 1 = idle/mark.
- busy  output  1  1 while a frame is in progress or the FIFO is non-empty.
- fifo_full  output  1  FIFO count == FIFO_DEPTH.
- overflow  output  1  sticky; set when a byte is dropped; cleared only by rst.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - tx=1, busy=0, fifo_full=0, overflow=0.
  - FIFO read/write pointers and count = 0.
  - FSM=IDLE; baud counter=0; bit index=0.
  - Reset mid-frame aborts the frame: tx returns to 1 at that edge, and buffered bytes are discarded.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit wrapping pointers and a separate count (0..FIFO_DEPTH).
  - Push when tx_wen=1 and (count<FIFO_DEPTH or a pop occurs the same cycle).
  - Push while full with no same-cycle pop: byte dropped, overflow<=1, FIFO unchanged.
  - Simultaneous push+pop: count unchanged, both pointers advance.
  - Pop only when the FSM loads a byte; never when count==0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If count>0: pop head into shift register, baud counter<=0, tx<=0, go START.
    - A byte written at edge E is not visible until after E, so its start bit appears at edge E+1 when the FSM is idle and the FIFO was empty. Latency from write edge to tx falling = 1 cycle.
  - START:
    - Hold tx=0 for exactly CLKS_PER_BIT cycles.
    - On terminal count: tx<=shift[0], bit index<=0, go DATA.
  - DATA:
    - Each bit is held exactly CLKS_PER_BIT cycles.
    - On terminal count: shift right, bit index++, tx<=next bit.
    - After bit 7's terminal count: tx<=1, go STOP.
  - STOP:
    - Hold tx=1 for CLKS_PER_BIT cycles.
    - On terminal count, if count>0: pop, tx<=0, go START directly, with no idle gap between frames. Otherwise go IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; terminal count at CLKS_PER_BIT-1, then wraps to 0.
  - Width $clog2(CLKS_PER_BIT).
  - Counts only outside IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from tx falling edge to the end of the stop bit.
- busy = (FSM!=IDLE) | (count!=0), registered or derived from registered state; must be 1 in the cycle after any accepted push.
- tx_data is latched into the FIFO at the push edge. Later changes of tx_data have no effect.
- tx never glitches: it is driven only by a flop.

Test Plan:
- Reset then idle (CLKS_PER_BIT=4, FIFO_DEPTH=4): hold rst 2 cycles, then 50 idle cycles -> tx=1, busy=0, fifo_full=0, overflow=0 throughout.
- Single byte: tx_wen=1 for one cycle with tx_data=8'hA5 -> tx falls 1 cycle after the write edge. Line then reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); busy drops in the cycle after the stop bit ends.
- Back-to-back: push 8'h00, 8'hFF, 8'h55 on consecutive cycles -> three frames with no idle cycle between them. Stop bit of frame N is followed immediately by the start bit of frame N+1; decoded bytes are 00, FF, 55 in order.
- Overflow: push 6 bytes (01..06) on consecutive cycles with FIFO_DEPTH=4:
  - Byte 01 is popped at the edge after its push, so 01..05 are accepted; fifo_full=1 after byte 05.
  - Byte 06 is dropped and overflow=1; overflow stays 1 after all frames complete.
  - Output sequence is 01,02,03,04,05.
- Push while full with pop same cycle: fill FIFO during a frame, then assert tx_wen on the STOP terminal-count cycle -> byte accepted, overflow stays 0, fifo_full stays 1.
- Reset mid-frame: push 8'h3C and 8'hC3, assert rst during bit 3 of the first frame -> tx=1 at the reset edge, busy=0, no further frames. Then push 8'h81 -> clean frame for 81 only.
